// File: rtl/mm_ram_arbiter.sv
// Two-requester arbiter for the single-port matrix RAM: host port 0, matmul control port 1.
// One owner at a time, lock for atomic sequences, bounded hold, fixed two-cycle read latency.
module mm_ram_arbiter #(
  parameter int DATA_W   = 32,
  parameter int RAM_D    = 512,
  parameter int ADDR_W   = $clog2(RAM_D),
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);

  state_t              state_q;
  logic                last_owner_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_d;
  logic                gnt0_q;
  logic                gnt1_q;
  logic                busy_q;

  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_w_data_q;
  logic                rd0_vld_p0;
  logic                rd1_vld_p0;
  logic                rd0_vld_p1;
  logic                rd1_vld_p1;

  logic                acc0;
  logic                acc1;
  logic                acc_any;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                at_limit;
  logic                rel0;
  logic                rel1;

  always_comb begin
    acc0      = gnt0_q & req0;
    acc1      = gnt1_q & req1;
    acc_any   = acc0 | acc1;
    acc_we    = acc1 ? we1 : we0;
    acc_addr  = acc1 ? addr1 : addr0;
    acc_wdata = acc1 ? wdata1 : wdata0;
    // Saturated counters count as at-limit so a late lock drop still yields.
    at_limit  = (hold_cnt_q >= HOLD_LAST);
    rel0      = ~lock0 & (~req0 | (acc0 & at_limit & req1));
    rel1      = ~lock1 & (~req1 | (acc1 & at_limit & req0));
    hold_cnt_d = hold_cnt_q;
    if (acc_any && (hold_cnt_q != HOLD_SAT)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      case (state_q)
        IDLE: begin
          if (req0 && (!req1 || last_owner_q)) begin
            state_q      <= OWN0;
            gnt0_q       <= 1'b1;
            busy_q       <= 1'b1;
            last_owner_q <= 1'b0;
            hold_cnt_q   <= '0;
          end else if (req1) begin
            state_q      <= OWN1;
            gnt1_q       <= 1'b1;
            busy_q       <= 1'b1;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
          end
        end
        OWN0: begin
          if (rel0) begin
            state_q <= TURN;
            gnt0_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        OWN1: begin
          if (rel1) begin
            state_q <= TURN;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        TURN:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage p0: accepted access launched to the RAM; read tag enters the valid pipe.
  // Stage p1: RAM returns data for the address launched in p0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_w_data_q <= '0;
      rd0_vld_p0   <= 1'b0;
      rd1_vld_p0   <= 1'b0;
      rd0_vld_p1   <= 1'b0;
      rd1_vld_p1   <= 1'b0;
    end else begin
      ram_we_q <= acc_any & acc_we;
      if (acc_any) begin
        ram_addr_q   <= acc_addr;
        ram_w_data_q <= acc_wdata;
      end
      rd0_vld_p0 <= acc0 & ~we0;
      rd1_vld_p0 <= acc1 & ~we1;
      rd0_vld_p1 <= rd0_vld_p0;
      rd1_vld_p1 <= rd1_vld_p0;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign busy       = busy_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_w_data = ram_w_data_q;
  assign rvalid0    = rd0_vld_p1;
  assign rvalid1    = rd1_vld_p1;
  assign rdata      = ram_r_data;

endmodule

// File: tb/tb_mm_ram_arbiter.sv
// Bench for mm_ram_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_mm_ram_arbiter;
  localparam int DW = 32;
  localparam int RD = 512;
  localparam int AW = 9;
  localparam int MH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
  logic [DW-1:0] rdata, ram_w_data, ram_r_data;
  logic [AW-1:0] ram_addr;

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] mem [RD];

  int vectors = 0;
  int miscompares = 0;

  mm_ram_arbiter #(.DATA_W(DW), .RAM_D(RD), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data), .busy(busy)
  );

  // Single-port RAM: registers the address, data appears one cycle later.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_w_data;
    ram_r_data <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  // Leaves the bench in "cycle 1": inputs set now are sampled at the first non-reset edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_we, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000", {gnt0, gnt1, rvalid0, rvalid1, ram_we, busy});
    end
    vectors++;
    if (ram_addr !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_addr: got %0d expected 0", ram_addr);
    end
    vectors++;
    if (ram_w_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_wdata: got %h expected 0", ram_w_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    preload(9'd5, 32'hDEADBEEF);
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'd5;
    vectors++;
    if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL sr_gnt_c1: got %b expected 0", gnt0); end
    tick();
    vectors++;
    if ({gnt0, gnt1, busy} !== 3'b101) begin
      miscompares++; $display("FAIL sr_gnt_c2: got %b expected 101", {gnt0, gnt1, busy});
    end
    tick();
    vectors++;
    if ({ram_addr, ram_we, rvalid0, gnt1} !== {9'd5, 3'b000}) begin
      miscompares++; $display("FAIL sr_c3: got addr %0d we %b rv %b g1 %b expected 5 0 0 0", ram_addr, ram_we, rvalid0, gnt1);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({rvalid0, gnt0, gnt1} !== 3'b100) begin
      miscompares++; $display("FAIL sr_rvalid_c4: got %b expected 100", {rvalid0, gnt0, gnt1});
    end
    vectors++;
    if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sr_rdata: got %h expected deadbeef", rdata); end
    tick();
    vectors++;
    if ({rvalid0, gnt1} !== 2'b00) begin
      miscompares++; $display("FAIL sr_c5: got %b expected 00", {rvalid0, gnt1});
    end
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 9'd1; addr1 = 9'd2;
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL tie_first: got %b expected 10", {gnt0, gnt1}); end
    req0 = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      tick();
      vectors++;
      if ({gnt0, gnt1} !== 2'b00) begin
        miscompares++; $display("FAIL tie_gap_c%0d: got %b expected 00", c, {gnt0, gnt1});
      end
    end
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 2'b01) begin miscompares++; $display("FAIL tie_second: got %b expected 01", {gnt0, gnt1}); end
    req0 = 1'b1;
    for (int c = 6; c <= 8; c++) begin
      tick();
      vectors++;
      if ({gnt0, gnt1} !== 2'b01) begin
        miscompares++; $display("FAIL tie_hold_c%0d: got %b expected 01", c, {gnt0, gnt1});
      end
    end
    for (int c = 9; c <= 10; c++) begin
      tick();
      vectors++;
      if ({gnt0, gnt1} !== 2'b00) begin
        miscompares++; $display("FAIL tie_turn_c%0d: got %b expected 00", c, {gnt0, gnt1});
      end
    end
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL tie_rr_back: got %b expected 10", {gnt0, gnt1}); end
    idle_inputs();
  endtask

  task automatic test_forced_release();
    for (int i = 0; i < 4; i++) preload(9'(100 + i), 32'hA000_0000 + i);
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'd100;
    tick();
    for (int c = 2; c <= 9; c++) begin
      vectors++;
      if ({gnt0, gnt1, rvalid1} !== {(c >= 8), (c <= 5), (c >= 4 && c <= 7)}) begin
        miscompares++;
        $display("FAIL fr_c%0d: got g0 %b g1 %b rv1 %b expected %b %b %b", c, gnt0, gnt1, rvalid1,
                 (c >= 8), (c <= 5), (c >= 4 && c <= 7));
      end
      if (c >= 4 && c <= 7) begin
        vectors++;
        if (rdata !== 32'hA000_0000 + (c - 4)) begin
          miscompares++; $display("FAIL fr_rdata_c%0d: got %h expected %h", c, rdata, 32'hA000_0000 + (c - 4));
        end
      end
      if (c == 2) begin req0 = 1'b1; addr0 = 9'd7; end
      if (c <= 5) addr1 = 9'(100 + c - 2);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 9'd200;
    tick();
    for (int c = 2; c <= 14; c++) begin
      vectors++;
      if ({gnt0, gnt1} !== {(c >= 14), (c <= 11)}) begin
        miscompares++;
        $display("FAIL lock_c%0d: got %b expected %b", c, {gnt0, gnt1}, {(c >= 14), (c <= 11)});
      end
      if (c == 2) req0 = 1'b1;
      if (c >= 8 && c <= 10) req1 = 1'b0;
      if (c == 11) begin req1 = 1'b1; lock1 = 1'b0; end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_readback();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'd510; wdata0 = 32'h12345678;
    tick();
    vectors++;
    if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL wr_gnt: got %b expected 1", gnt0); end
    tick();
    vectors++;
    if ({ram_we, ram_addr, ram_w_data} !== {1'b1, 9'd510, 32'h12345678}) begin
      miscompares++; $display("FAIL wr_ram: got we %b addr %0d data %h expected 1 510 12345678", ram_we, ram_addr, ram_w_data);
    end
    we0 = 1'b0;
    tick();
    vectors++;
    if ({ram_we, ram_addr, rvalid0} !== {1'b0, 9'd510, 1'b0}) begin
      miscompares++; $display("FAIL rd_ram: got we %b addr %0d rv %b expected 0 510 0", ram_we, ram_addr, rvalid0);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({rvalid0, rdata} !== {1'b1, 32'h12345678}) begin
      miscompares++; $display("FAIL readback: got rv %b data %h expected 1 12345678", rvalid0, rdata);
    end
    tick();
    vectors++;
    if (rvalid0 !== 1'b0) begin miscompares++; $display("FAIL readback_once: got %b expected 0", rvalid0); end
  endtask

  task automatic test_reset_mid_burst();
    preload(9'd100, 32'hA000_0000);
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'd100;
    tick();
    vectors++;
    if (gnt1 !== 1'b1) begin miscompares++; $display("FAIL rm_gnt: got %b expected 1", gnt1); end
    tick();
    addr1 = 9'd101;
    tick();
    vectors++;
    if ({rvalid1, rdata} !== {1'b1, 32'hA000_0000}) begin
      miscompares++; $display("FAIL rm_first: got rv %b data %h expected 1 a0000000", rvalid1, rdata);
    end
    rst = 1'b1; req1 = 1'b0;
    tick();
    vectors++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_we, busy} !== 6'b0) begin
      miscompares++; $display("FAIL rm_cleared: got %b expected 000000", {gnt0, gnt1, rvalid0, rvalid1, ram_we, busy});
    end
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    vectors++;
    if ({gnt0, gnt1, rvalid1} !== 3'b100) begin
      miscompares++; $display("FAIL rm_tie: got %b expected 100", {gnt0, gnt1, rvalid1});
    end
    tick();
    vectors++;
    if (rvalid1 !== 1'b0) begin miscompares++; $display("FAIL rm_stale: got %b expected 0", rvalid1); end
    idle_inputs();
  endtask

  task automatic test_random_traffic();
    logic [DW-1:0] ref_mem [16];
    int            m_owner, m_last, m_hold, acc, x;
    bit            m_turn, rel;
    bit            s0_v, s1_v;
    int            s0_p, s1_p;
    logic [DW-1:0] s0_d, s1_d;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    bit            rq [2];
    bit            lk [2];
    bit            wr [2];
    bit            acc_prev [2];
    logic [3:0]    ad [2];
    logic [DW-1:0] wd [2];
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      preload(9'(i), ref_mem[i]);
    end
    do_reset();
    m_owner = -1; m_last = 1; m_hold = 0; m_turn = 0;
    s0_v = 0; s1_v = 0; s0_p = 0; s1_p = 0; s0_d = '0; s1_d = '0;
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; lk[p] = 0; wr[p] = 0; acc_prev[p] = 0; ad[p] = '0; wd[p] = '0;
    end
    for (int n = 0; n < 600; n++) begin
      // A requester keeps its access stable until it is accepted.
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] || acc_prev[p]) begin
          rq[p] = ($urandom_range(0, 3) != 0);
          wr[p] = ($urandom_range(0, 2) == 0);
          ad[p] = 4'($urandom_range(0, 15));
          wd[p] = $urandom;
        end
        if ($urandom_range(0, 15) == 0) lk[p] = !lk[p];
      end
      req0 = rq[0]; lock0 = lk[0]; we0 = wr[0]; addr0 = {5'd0, ad[0]}; wdata0 = wd[0];
      req1 = rq[1]; lock1 = lk[1]; we1 = wr[1]; addr1 = {5'd0, ad[1]}; wdata1 = wd[1];
      acc = -1;
      if (m_owner == 0 && rq[0]) acc = 0;
      else if (m_owner == 1 && rq[1]) acc = 1;
      tick();
      s1_v = s0_v; s1_p = s0_p; s1_d = s0_d; s0_v = 0; e_we = 1'b0;
      acc_prev[0] = (acc == 0); acc_prev[1] = (acc == 1);
      if (acc >= 0) begin
        e_we = wr[acc]; e_addr = {5'd0, ad[acc]}; e_wd = wd[acc];
        if (wr[acc]) ref_mem[ad[acc]] = wd[acc];
        else begin s0_v = 1; s0_p = acc; s0_d = ref_mem[ad[acc]]; end
      end
      if (m_turn) begin
        m_turn = 0;
      end else if (m_owner < 0) begin
        if (rq[0] && rq[1]) m_owner = 1 - m_last;
        else if (rq[0]) m_owner = 0;
        else if (rq[1]) m_owner = 1;
        if (m_owner >= 0) begin m_last = m_owner; m_hold = 0; end
      end else begin
        x = m_owner;
        rel = (!rq[x] && !lk[x]) || (acc == x && m_hold >= MH - 1 && rq[1 - x] && !lk[x]);
        if (acc == x && m_hold < MH) m_hold++;
        if (rel) begin m_owner = -1; m_turn = 1; end
      end
      vectors++;
      if ({gnt0, gnt1, busy} !== {(m_owner == 0), (m_owner == 1), (m_owner >= 0)}) begin
        miscompares++;
        $display("FAIL rnd_grant n=%0d: got %b expected %b", n, {gnt0, gnt1, busy},
                 {(m_owner == 0), (m_owner == 1), (m_owner >= 0)});
      end
      vectors++;
      if ({ram_we, ram_addr, ram_w_data} !== {e_we, e_addr, e_wd}) begin
        miscompares++;
        $display("FAIL rnd_ram n=%0d: got we %b addr %0d data %h expected %b %0d %h", n,
                 ram_we, ram_addr, ram_w_data, e_we, e_addr, e_wd);
      end
      vectors++;
      if ({rvalid0, rvalid1} !== {(s1_v && s1_p == 0), (s1_v && s1_p == 1)}) begin
        miscompares++;
        $display("FAIL rnd_rvalid n=%0d: got %b expected %b", n, {rvalid0, rvalid1},
                 {(s1_v && s1_p == 0), (s1_v && s1_p == 1)});
      end
      if (s1_v) begin
        vectors++;
        if (rdata !== s1_d) begin
          miscompares++; $display("FAIL rnd_rdata n=%0d: got %h expected %h", n, rdata, s1_d);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_tie_round_robin();
    test_forced_release();
    test_lock();
    test_write_readback();
    test_reset_mid_burst();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mm_ram_arbiter.md
Name: mm_ram_arbiter

Overview:
- Shares the single-port matrix RAM between two requesters: port 0 (host loader / result reader) and port 1 (matrix multiply control unit).
- Grants one owner at a time.
- Supports a lock for atomic operand-fetch sequences.
- Enforces a bounded hold time so neither side starves.
- Sits between both masters and the RAM. Registered RAM-side outputs and a fixed read latency give predictable timing.

Parameters:
- DATA_W, 32, RAM word width.
- RAM_D, 512, RAM depth in words.
- ADDR_W, $clog2(RAM_D), RAM address width.
- MAX_HOLD, 16, max accesses per grant before forced release when the other port is waiting (must be ≥1).
- HOLD_W, $clog2(MAX_HOLD+1), hold counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req0, req1  in  1  access request per port
- lock0, lock1  in  1  keep grant even if req low; blocks forced release
- we0, we1  in  1  write enable of the requested access
- addr0, addr1  in  ADDR_W  access address
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  registered grant; never both high
- rvalid0, rvalid1  out  1  read data valid for that port
- rdata  out  DATA_W  read data, shared; wired directly from ram_r_data
- ram_we  out  1  registered RAM write enable
- ram_addr  out  ADDR_W  registered RAM address
- ram_w_data  out  DATA_W  registered RAM write data
- ram_r_data  in  DATA_W  RAM read data; the RAM registers the address and returns data 1 cycle after the address is presented
- busy  out  1  high when an owner is granted

Behaviour:
- Reset values:
  - gnt0, gnt1, rvalid0, rvalid1, ram_we, busy = 0.
  - ram_addr, ram_w_data = 0.
  - State = IDLE, last_owner = 1 (port 0 wins first tie), hold_cnt = 0.
- Reset mid-operation drops the grant immediately. Pending rvalid pipeline stages are cleared, so no rvalid is issued after reset.
- States: IDLE, OWN0, OWN1, TURN.
- Accept: an access is accepted in cycle c iff gntX=1 and reqX=1 in cycle c.
  - At the end-of-c edge: ram_we ← weX, ram_addr ← addrX, ram_w_data ← wdataX, hold_cnt++.
  - Any cycle without an accept: ram_we ← 0; ram_addr and ram_w_data hold their values.
- Read latency: a read accepted in cycle c has rvalidX=1 for exactly one cycle, in c+2, with rdata valid in that cycle. Writes never raise rvalid. Back-to-back reads give one rvalid per accept, in order.
- IDLE:
  - Only one req high → move to that port's OWN state.
  - Both high → grant the port ≠ last_owner.
  - gnt rises the cycle after req is seen (req in c, gnt in c+1). Accept is possible in c+1.
  - Entering OWNx: hold_cnt ← 0, last_owner ← x.
- OWNx: gntX=1, busy=1. Release at the end of a cycle when any of the following holds:
  - (a) reqX=0 and lockX=0;
  - (b) an accept occurs in that cycle with hold_cnt = MAX_HOLD−1, req of the other port = 1, and lockX=0.
  - lockX=1 overrides both rules: the grant persists indefinitely, including idle cycles with reqX=0.
  - Release → TURN.
- TURN: one cycle with gnt0=gnt1=0 and ram_we=0 (bus turnaround), then IDLE. Minimum grant-to-grant gap is 2 idle cycles.
- Hold at MAX_HOLD with the other port idle: no release; hold_cnt saturates at MAX_HOLD.
- Requester rule: the requester holds we, addr and wdata valid while req is high. A req dropped and re-raised under lock resumes without re-arbitration.
- rdata is not gated; only rvalid qualifies it.

Test Plan:
- Single read: reset, RAM[5]=0xDEADBEEF; req0=1, we0=0, addr0=5 from cycle 1 → gnt0 in cycle 2; ram_addr=5 in cycle 3; rvalid0=1 with rdata=0xDEADBEEF in cycle 4 only; gnt1 never high.
- Tie after reset: req0=req1=1 in the same cycle → gnt0 first. Drop req0 → TURN cycle with both gnt low, then gnt1. Re-raise req0 with req1 still held → gnt0 after port 1 releases (round-robin).
- Forced release, MAX_HOLD=4: port 1 streams reads, port 0 requests from the start → exactly 4 accepts for port 1, then TURN, then gnt0; four rvalid1 pulses precede gnt0's first accept.
- Lock: as the previous case but lock1=1 → port 1 keeps the grant past 4 accepts, including gaps with req1=0. Lower lock1 → release after the next accept (hold_cnt saturated), then gnt0.
- Write/readback: port 0 writes 0x12345678 to addr 510 (ram_we=1 for one cycle, ram_addr=510), then reads addr 510 → rvalid0 with rdata=0x12345678.
- Reset mid-burst: port 1 with 2 reads in flight, assert rst for 1 cycle → all gnt/rvalid/ram_we 0 the next cycle; no stale rvalid afterwards; next arbitration grants port 0 first on a tie.
